// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a writeback forwarding tap on the head entry.
module memwb_pipe_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 3,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned FWD_CH = 0
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]       in_rd,
  input  logic                  in_we,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]       out_rd,
  output logic                  out_we,
  output logic                  fwd_valid,
  output logic [RD_W-1:0]       fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
);

  localparam int unsigned BusW = NCH * DATA_W;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } state_e;

  state_e state_q, state_d;

  logic [BusW-1:0] main_data_q, main_data_d;
  logic [RD_W-1:0] main_rd_q, main_rd_d;
  logic            main_we_q, main_we_d;

  logic [BusW-1:0] skid_data_q, skid_data_d;
  logic [RD_W-1:0] skid_rd_q, skid_rd_d;
  logic            skid_we_q, skid_we_d;

  logic accept;
  logic pop;

  // Ready comes straight from the state register, never from out_ready.
  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_we_d   = main_we_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_we_d   = skid_we_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_data_d = in_data;
          main_rd_d   = in_rd;
          main_we_d   = in_we;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          main_data_d = in_data;
          main_rd_d   = in_rd;
          main_we_d   = in_we;
        end else if (accept) begin
          skid_data_d = in_data;
          skid_rd_d   = in_rd;
          skid_we_d   = in_we;
          state_d     = StTwo;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (pop) begin
          main_data_d = skid_data_q;
          main_rd_d   = skid_rd_q;
          main_we_d   = skid_we_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush wins over any simultaneous accept; a same-cycle pop already left.
    if (flush) begin
      state_d   = StEmpty;
      main_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_we_q   <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_we_q   <= main_we_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_we_q   <= skid_we_d;
    end
  end

  assign out_data = main_data_q;
  assign out_rd   = main_rd_q;
  // A stale write enable left in main after a pop must not leak out.
  assign out_we   = out_valid & main_we_q;

  assign fwd_valid = out_valid & out_we & (out_rd != '0);
  assign fwd_rd    = out_rd;
  assign fwd_data  = main_data_q[FWD_CH*DATA_W +: DATA_W];

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Scoreboard bench for memwb_pipe_stage: a capacity-2 FIFO model predicts
// readiness and the head entry; a negedge monitor compares and pops.
module tb_memwb_pipe_stage;

  localparam int unsigned DW   = 32;
  localparam int unsigned NC   = 3;
  localparam int unsigned RW   = 5;
  localparam int unsigned FC   = 0;
  localparam int unsigned BW   = NC * DW;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [RW-1:0] rd;
    logic          we;
  } entry_t;

  logic          clk = 1'b0;
  logic          Reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [RW-1:0] in_rd;
  logic          in_we;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [RW-1:0] out_rd;
  logic          out_we;
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;

  memwb_pipe_stage #(
    .DATA_W(DW),
    .NCH   (NC),
    .RD_W  (RW),
    .FWD_CH(FC)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .in_we    (in_we),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_rd   (out_rd),
    .out_we   (out_we),
    .fwd_valid(fwd_valid),
    .fwd_rd   (fwd_rd),
    .fwd_data (fwd_data)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     delivered = 0;
  entry_t sb[$];
  logic   snap_ok = 1'b0;
  logic   snap_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Push side: an entry is expected once the model says it was accepted.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      if (Reset && snap_ok) begin
        if (flush) begin
          sb.delete();
        end else if (in_valid && snap_ready) begin
          e.data = in_data;
          e.rd   = in_rd;
          e.we   = in_we;
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: compares DUT against the model head, pops on delivery.
  initial begin
    entry_t h;
    logic   exp_ready;
    forever begin
      @(negedge clk);
      if (!Reset) begin
        snap_ok = 1'b0;
      end else begin
        exp_ready = (sb.size() < 2);
        check("in_ready", 128'(in_ready), 128'(exp_ready));
        check("out_valid", 128'(out_valid), 128'(sb.size() > 0));
        if (sb.size() > 0) begin
          h = sb[0];
          check("out_data", 128'(out_data), 128'(h.data));
          check("out_rd", 128'(out_rd), 128'(h.rd));
          check("out_we", 128'(out_we), 128'(h.we));
          check("fwd_valid", 128'(fwd_valid), 128'(h.we && (h.rd != 0)));
          check("fwd_rd", 128'(fwd_rd), 128'(h.rd));
          check("fwd_data", 128'(fwd_data), 128'(h.data[FC*DW +: DW]));
          if (out_ready) begin
            void'(sb.pop_front());
            delivered++;
          end
        end else begin
          check("idle_out_we", 128'(out_we), 128'(0));
          check("idle_fwd_valid", 128'(fwd_valid), 128'(0));
        end
        snap_ready = exp_ready;
        snap_ok    = 1'b1;
      end
    end
  end

  task automatic step(input logic iv, input logic [BW-1:0] d, input logic [RW-1:0] r,
                      input logic w, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = d;
    in_rd     = r;
    in_we     = w;
    out_ready = ordy;
    flush     = fl;
  endtask

  function automatic logic [BW-1:0] mk(input logic [DW-1:0] c2, input logic [DW-1:0] c1,
                                       input logic [DW-1:0] c0);
    return {c2, c1, c0};
  endfunction

  initial begin
    Reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = mk(32'd9, 32'd8, 32'd7);
    in_rd     = 5'd3;
    in_we     = 1'b1;
    out_ready = 1'b1;

    // Reset with valid input pending.
    #12;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_fwd_valid", 128'(fwd_valid), 128'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Reset    = 1'b1;

    // First entry, latency 1.
    step(1'b1, mk(32'd3, 32'd2, 32'd1), 5'd7, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("t1_out_valid", 128'(out_valid), 128'(1));
    check("t1_out_data", 128'(out_data), 128'(mk(32'd3, 32'd2, 32'd1)));
    check("t1_fwd", 128'({fwd_valid, fwd_rd, fwd_data}), 128'({1'b1, 5'd7, 32'd1}));

    // Streaming 0..7.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mk(32'(i), 32'(i), 32'(i)), 5'(i + 1), 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Backpressure: A, B fill the stage, C waits upstream.
    step(1'b1, mk(32'hA, 32'hA, 32'hA), 5'd10, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(32'hB, 32'hB, 32'hB), 5'd11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(32'hC, 32'hC, 32'hC), 5'd12, 1'b1, 1'b0, 1'b0);
    end
    check("t3_full_in_ready", 128'(in_ready), 128'(0));
    step(1'b1, mk(32'hC, 32'hC, 32'hC), 5'd12, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Flush while full, with a new entry offered the same cycle.
    step(1'b1, mk(32'hD1, 32'hD1, 32'hD1), 5'd13, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(32'hD2, 32'hD2, 32'hD2), 5'd14, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(32'hD3, 32'hD3, 32'hD3), 5'd15, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("t4_out_valid", 128'(out_valid), 128'(0));
    check("t4_in_ready", 128'(in_ready), 128'(1));
    step(1'b1, mk(32'hE, 32'hE, 32'hE), 5'd16, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Forwarding gating.
    step(1'b1, mk(32'h10, 32'h10, 32'h10), 5'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(32'h11, 32'h11, 32'h11), 5'd5, 1'b0, 1'b1, 1'b0);
    step(1'b1, mk(32'h12, 32'h12, 32'h12), 5'd5, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while full.
    step(1'b1, mk(32'h20, 32'h20, 32'h20), 5'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, mk(32'h21, 32'h21, 32'h21), 5'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("t6_pre_full", 128'(in_ready), 128'(0));
    #2;
    Reset = 1'b0;
    #1;
    check("t6_async_out_valid", 128'(out_valid), 128'(0));
    check("t6_async_in_ready", 128'(in_ready), 128'(1));
    check("t6_async_out_data", 128'(out_data), 128'(0));
    check("t6_async_fwd", 128'({out_we, fwd_valid}), 128'(0));
    sb.delete();
    snap_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b1;
    step(1'b1, mk(32'h30, 32'h31, 32'h32), 5'd9, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("t6_latency", 128'({out_valid, out_data}), 128'({1'b1, mk(32'h30, 32'h31, 32'h32)}));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, {$urandom, $urandom, $urandom}, 5'($urandom), 1'($urandom),
           ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check("drain_empty", 128'(sb.size()), 128'(0));
    check("delivered_any", 128'(delivered > 50), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/memwb_pipe_stage.md
Name: memwb_pipe_stage

Overview:
- Parametrised successor to the fixed three-word MEM/WB register.
- Carries NCH data channels plus writeback control (rd, we) across a pipeline boundary.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and a writeback forwarding tap.
- Sits between the MEM stage and the register-file write port; usable at any stage boundary.

Parameters:
- DATA_W, 32, width of one data channel
- NCH, 3, number of data channels carried
- RD_W, 5, destination register index width
- FWD_CH, 0, channel index driven onto fwd_data (0..NCH-1)

Ports:
- clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_data  in  NCH*DATA_W  channels, channel k at bits [k*DATA_W +: DATA_W]
- in_rd  in  RD_W  destination register
- in_we  in  1  register write enable
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_data  out  NCH*DATA_W  head data
- out_rd  out  RD_W  head destination
- out_we  out  1  head write enable
- fwd_valid  out  1  forwarding tap active
- fwd_rd  out  RD_W  forwarded register index
- fwd_data  out  DATA_W  forwarded value, channel FWD_CH of the head

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- While Reset=0:
  - out_valid=0, out_we=0, out_rd=0, out_data=0.
  - Skid entry cleared to 0 and marked empty.
  - in_ready=1, fwd_valid=0.
- Storage: main register (drives out_*) and skid register. States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - TWO: both valid.
- in_ready is registered: in_ready = (state != TWO). It never depends combinationally on out_ready.
- Handshakes: accept occurs when in_valid & in_ready; pop occurs when out_valid & out_ready.
- Transitions, no flush:
  - EMPTY + accept -> ONE: input loaded to main, visible next cycle (latency 1).
  - ONE + accept + pop -> ONE: main reloaded with input.
  - ONE + accept, no pop -> TWO: input captured in skid; in_ready=0 next cycle.
  - ONE + pop, no accept -> EMPTY.
  - TWO + pop -> ONE: skid moves to main. No accept is possible in TWO.
  - No handshake -> hold all registers unchanged.
- Ordering is strictly FIFO. No entry is dropped or duplicated under any backpressure pattern.
- out_data, out_rd and out_we remain stable while out_valid=1 and out_ready=0.
- flush=1 at a clock edge:
  - Next state EMPTY: out_valid=0, out_we=0, skid emptied, in_ready=1.
  - Overrides any simultaneous accept; the input entry is discarded.
  - A simultaneous pop still counts as delivered downstream that cycle.
  - Data and rd registers are not required to clear.
- Forwarding tap (combinational from registers only):
  - fwd_valid = out_valid & out_we & (out_rd != 0).
  - fwd_rd = out_rd.
  - fwd_data = out_data channel FWD_CH.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- No arithmetic is performed; widths pass through unchanged.

Test Plan:
1. Reset=0 with in_valid=1 -> out_valid=0, out_data=0, in_ready=1. Release reset, send {C2=3,C1=2,C0=1}, rd=7, we=1, out_ready=1 -> next cycle out_valid=1, out_data channels 1/2/3, fwd_valid=1, fwd_rd=7, fwd_data=1.
2. Streaming: in_valid=1 and out_ready=1 for 8 cycles, data 0..7 -> out_data emits 0..7 in order, one per cycle, in_ready stays 1.
3. Backpressure: hold out_ready=0, push A then B -> state TWO, in_ready=0, C held upstream. Raise out_ready -> output sequence A, B, C with no loss or duplication; out_data stable while stalled.
4. Flush in state TWO with simultaneous in_valid=1 -> next cycle out_valid=0, in_ready=1, skid empty; neither the held entries nor the new entry ever appears at the output.
5. Forwarding gating: entry with rd=0, we=1 -> fwd_valid=0. Entry with rd=5, we=0 -> fwd_valid=0. Entry with rd=5, we=1 -> fwd_valid=1.
6. Reset pulse mid-cycle while in state TWO -> outputs clear asynchronously before the next edge. After release, first accepted entry appears with latency 1.
